// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the compare pulse generator.
// Holds the state encoding and the default timebase width.
package pulse_gen_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_compare.sv
// Saturating cycle counter with a greater-or-equal compare.
// start loads 1 so the value equals cycles spent including the current one.
module counter_compare #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_i,
  input  logic             start_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] lim_i,
  output logic             ge_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // next count: load on start, otherwise count up and stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = WIDTH'(1);
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + WIDTH'(1);
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (ena_i)
      cnt_q <= cnt_d;
  end

  assign ge_o = (cnt_q >= lim_i);

endmodule

// File: rtl/compare_pulse_gen.sv
// Compare-match pulse generator on a shared timebase, with ld shadowing.
// Define PULSE_GEN_MINW_EN to add minw_val, a minimum active width in cycles.
module compare_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] on_val,
  input  logic [WIDTH-1:0] off_val,
`ifdef PULSE_GEN_MINW_EN
  input  logic [WIDTH-1:0] minw_val,
`endif
  input  logic             ld,
  input  logic             arm,
  input  logic             abort,
  input  logic             cont,
  input  logic             pol,
  output logic             pin,
  output logic             on_evt,
  output logic             off_evt,
  output logic             busy
);

  state_e           st_q, st_d;
  logic             act_q, act_d;
  logic             pin_q, pin_d;
  logic             onev_q, onev_d;
  logic             offev_q, offev_d;
  logic [WIDTH-1:0] sh_on_q, sh_on_d;
  logic [WIDTH-1:0] sh_off_q, sh_off_d;
  logic [WIDTH-1:0] a_on_q, a_on_d;
  logic [WIDTH-1:0] a_off_q, a_off_d;
  logic             pend_q, pend_d;
  logic             on_hit, off_hit, off_go, xfer;

  assign on_hit  = (cnt == a_on_q);
  assign off_hit = (cnt == a_off_q);

`ifdef PULSE_GEN_MINW_EN
  logic lat_q, lat_d;
  logic minw_ok;

  counter_compare #(.WIDTH(WIDTH)) u_minw (
    .clk     (clk),
    .rst     (rst),
    .ena_i   (ena),
    .start_i ((st_d == ACTIVE) && (st_q != ACTIVE)),
    .inc_i   (st_q == ACTIVE),
    .lim_i   (minw_val),
    .ge_o    (minw_ok)
  );

  assign off_go = (off_hit || lat_q) && minw_ok;

  // remember an off match until the minimum width has elapsed
  always_comb begin
    lat_d = lat_q;
    if ((st_q == ACTIVE) && off_hit)
      lat_d = 1'b1;
    if (st_d != ACTIVE)
      lat_d = 1'b0;
  end
`else
  assign off_go = off_hit;
`endif

  // state sequencing, events and compare-value shadowing
  always_comb begin
    st_d     = st_q;
    act_d    = act_q;
    onev_d   = 1'b0;
    offev_d  = 1'b0;
    sh_on_d  = sh_on_q;
    sh_off_d = sh_off_q;
    a_on_d   = a_on_q;
    a_off_d  = a_off_q;
    pend_d   = pend_q;
    if (abort) begin
      st_d    = IDLE;
      act_d   = 1'b0;
      offev_d = act_q;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (arm)
            st_d = ARMED;
        end
        ARMED: begin
          if (on_hit) begin
            st_d   = ACTIVE;
            act_d  = 1'b1;
            onev_d = 1'b1;
          end
        end
        ACTIVE: begin
          if (off_go) begin
            st_d    = cont ? ARMED : IDLE;
            act_d   = 1'b0;
            offev_d = 1'b1;
          end
        end
        default: begin
          st_d  = IDLE;
          act_d = 1'b0;
        end
      endcase
    end
    xfer = pend_q &&
           ((st_q == IDLE) ||
            ((st_q == ACTIVE) && (st_d != ACTIVE)));
    if (ld) begin
      sh_on_d  = on_val;
      sh_off_d = off_val;
      pend_d   = 1'b1;
    end else if (xfer) begin
      a_on_d  = sh_on_q;
      a_off_d = sh_off_q;
      pend_d  = 1'b0;
    end
    pin_d = act_d ^ pol;
  end

  // state and output registers; reset drives pin to the inactive level
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      act_q    <= 1'b0;
      pin_q    <= pol;
      onev_q   <= 1'b0;
      offev_q  <= 1'b0;
      sh_on_q  <= '0;
      sh_off_q <= '0;
      a_on_q   <= '0;
      a_off_q  <= '0;
      pend_q   <= 1'b0;
    end else if (ena) begin
      st_q     <= st_d;
      act_q    <= act_d;
      pin_q    <= pin_d;
      onev_q   <= onev_d;
      offev_q  <= offev_d;
      sh_on_q  <= sh_on_d;
      sh_off_q <= sh_off_d;
      a_on_q   <= a_on_d;
      a_off_q  <= a_off_d;
      pend_q   <= pend_d;
    end
  end

`ifdef PULSE_GEN_MINW_EN
  // off-match latch register
  always_ff @(posedge clk) begin
    if (rst)
      lat_q <= 1'b0;
    else if (ena)
      lat_q <= lat_d;
  end
`endif

  assign pin     = pin_q;
  assign on_evt  = onev_q;
  assign off_evt = offev_q;
  assign busy    = (st_q != IDLE);

endmodule

// File: doc/compare_pulse_gen.md
COMPARE_PULSE_GEN -- requirements
Module: compare_pulse_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, timebase and compare-value width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ena  input  1  clock enable; when low, all state, counters and outputs hold.
REQ-005 SHALL have port cnt  input  WIDTH  free-running timebase value.
REQ-006 SHALL have ports on_val, off_val  input  WIDTH  each; compare values for output assertion and deassertion.
REQ-007 SHALL have port ld  input  1  strobe; captures on_val/off_val into shadow registers.
REQ-008 SHALL have ports arm, abort  input  1  each; start and cancel strobes.
REQ-009 SHALL have port cont  input  1  0 = one-shot, 1 = continuous.
REQ-010 SHALL have port pol  input  1  output polarity; 1 = active-low pin.
REQ-011 SHALL have port pin  output  1  registered output: active flag XOR pol.
REQ-012 SHALL have ports on_evt, off_evt  output  1  each; one-cycle pulses when pin goes active or inactive.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ARMED and ACTIVE.
REQ-015 SHALL go IDLE->ARMED on arm; arm in ARMED or ACTIVE is ignored.
REQ-016 SHALL go ARMED->ACTIVE when cnt equals the active on value.
REQ-017 SHALL go ACTIVE->ARMED (cont=1) or ACTIVE->IDLE (cont=0) when cnt equals the active off value.
REQ-018 SHALL register outputs: a compare match in cycle n changes pin, and pulses on_evt/off_evt, in cycle n+1.
REQ-019 SHALL compare the off value only in ACTIVE; when on_val equals off_val, the pulse lasts one full timebase wrap (2^WIDTH counts).
REQ-020 SHALL make abort send any state to IDLE next cycle; if pin was active, it deasserts and off_evt pulses.
REQ-021 SHALL give abort priority over arm and over any compare match in the same cycle.
REQ-022 SHALL copy the shadow registers to the active compare registers, and clear the pending flag, when ld is pending and the block is IDLE or leaving ACTIVE.
REQ-023 SHALL let the newest ld win when ld and a transfer occur in the same cycle; the transfer takes effect on the next transfer opportunity.
REQ-024 SHALL never change the active compare values while ARMED or mid-pulse, apart from the ACTIVE-exit transfer.
REQ-025 SHALL make a change of pol affect pin on the next cycle without generating on_evt/off_evt.

Reset
REQ-026 SHALL, on rst, set state to IDLE, the active flag to 0, and pin to pol.
REQ-027 SHALL, on rst, set on_evt, off_evt and busy to 0, and clear the shadow registers, active registers and pending flag.
REQ-028 SHALL give rst priority over ena and every other input.
REQ-029 SHALL return to IDLE with pin inactive if rst is asserted mid-pulse, with no off_evt.

Configuration
REQ-030 SHALL, when PULSE_GEN_MINW_EN is defined, add port minw_val (input, WIDTH, minimum active width in clk cycles).
REQ-031 SHALL, with PULSE_GEN_MINW_EN, count cycles in ACTIVE, latch an off match, and deassert only once the latched match holds and count >= minw_val.
REQ-032 SHALL, with PULSE_GEN_MINW_EN, stop the width counter at saturation instead of wrapping.
REQ-033 SHALL, without PULSE_GEN_MINW_EN, have no minw_val port and deassert on the off match alone, as in REQ-017.

Structure
REQ-034 SHALL place the state enum (IDLE/ARMED/ACTIVE) and the default WIDTH constant in shared package pulse_gen_pkg.
REQ-035 SHALL implement the min-width counter by instantiating existing counter_compare; no other sub-module.

Verification
REQ-036 SHALL check: WIDTH=8, ld on=10 off=20, arm, cont=0 -> pin active at the cycle after cnt==10, inactive after cnt==20, on_evt/off_evt once each, busy low after.
REQ-037 SHALL check: cont=1, on=5 off=5 -> pin active for 256 cnt steps, then re-arms and repeats; busy stays high.
REQ-038 SHALL check: abort and arm in the same cycle while ACTIVE -> IDLE, off_evt pulses, and a second arm restarts.
REQ-039 SHALL check: ld of on=30 off=40 during ACTIVE of a 10/20 pulse -> current pulse ends at 20, next pulse uses 30/40.
REQ-040 SHALL check: PULSE_GEN_MINW_EN, on=10 off=11, minw_val=5, timebase stepping every clk -> pin active exactly 5 cycles.
REQ-041 SHALL check: pol=1 and rst asserted mid-pulse -> pin=1 the next cycle, no events, state IDLE.
